// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// sram_port_arbiter: fair read/write arbiter in front of a single-port SRAM
// macro, with a one-entry read response buffer. Optional macro
// SRAM_ARB_INIT_CLEAR_EN zero-fills the macro during INIT.
// Revision: 1.0
// ============================================================================
module sram_port_arbiter #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [ADDR_W-1:0] r_req_addr,
  output logic              r_resp_valid,
  input  logic              r_resp_ready,
  output logic [DATA_W-1:0] r_resp_data,
  input  logic              w_req_valid,
  output logic              w_req_ready,
  input  logic [ADDR_W-1:0] w_req_addr,
  input  logic [DATA_W-1:0] w_req_data,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q,
  output logic              init_done
);

  if (DEPTH > (1 << ADDR_W)) begin : g_depth_check
    $error("sram_port_arbiter: DEPTH does not fit in ADDR_W address bits");
  end

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state;
  logic              last_grant_wr;
  logic              rd_in_flight;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;

  logic run;
  logic rd_elig;
  logic rd_want;
  logic wr_want;
  logic grant_rd;
  logic grant_wr;
  logic init_wr;

  // Gating with reset keeps every output at its idle value while reset is held.
  assign run      = (state == ST_RUN) && !reset;
  assign rd_elig  = run && !rd_in_flight && (!resp_valid || r_resp_ready);
  assign rd_want  = r_req_valid && rd_elig;
  assign wr_want  = w_req_valid && run;
  assign grant_rd = rd_want && (!wr_want || last_grant_wr);
  assign grant_wr = wr_want && !grant_rd;

`ifdef SRAM_ARB_INIT_CLEAR_EN
  logic [ADDR_W-1:0] init_addr;
  assign init_wr = (state == ST_INIT) && !reset;
`else
  assign init_wr = 1'b0;
`endif

  always_comb begin
    sram_ceb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (init_wr) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
`ifdef SRAM_ARB_INIT_CLEAR_EN
      sram_a   = init_addr;
`endif
    end else if (grant_wr) begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = w_req_addr;
      sram_d   = w_req_data;
    end else if (grant_rd) begin
      sram_ceb = 1'b0;
      sram_a   = r_req_addr;
    end
  end

  assign r_req_ready  = grant_rd;
  assign w_req_ready  = grant_wr;
  assign r_resp_valid = resp_valid && !reset;
  assign r_resp_data  = resp_data;
  assign init_done    = (state == ST_RUN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_INIT;
      last_grant_wr <= 1'b1;
      rd_in_flight  <= 1'b0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
`ifdef SRAM_ARB_INIT_CLEAR_EN
      init_addr     <= '0;
`endif
    end else begin
      rd_in_flight <= grant_rd;
      if (grant_rd || grant_wr) begin
        last_grant_wr <= grant_wr;
      end
      // A read is only granted into an empty (or draining) buffer, so the
      // capture never collides with an unconsumed response.
      if (rd_in_flight) begin
        resp_valid <= 1'b1;
        resp_data  <= sram_q;
      end else if (resp_valid && r_resp_ready) begin
        resp_valid <= 1'b0;
      end
      case (state)
        ST_INIT: begin
`ifdef SRAM_ARB_INIT_CLEAR_EN
          init_addr <= init_addr + 1'b1;
          if (init_addr == ADDR_W'(DEPTH - 1)) begin
            state <= ST_RUN;
          end
`else
          state <= ST_RUN;
`endif
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_port_arbiter: directed + randomized scoreboard bench for
// sram_port_arbiter, with a behavioural SRAM macro and a reference memory.
// Revision: 1.0
// ============================================================================
module tb_sram_port_arbiter;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              r_req_valid = 1'b0;
  logic              r_req_ready;
  logic [ADDR_W-1:0] r_req_addr = '0;
  logic              r_resp_valid;
  logic              r_resp_ready = 1'b0;
  logic [DATA_W-1:0] r_resp_data;
  logic              w_req_valid = 1'b0;
  logic              w_req_ready;
  logic [ADDR_W-1:0] w_req_addr = '0;
  logic [DATA_W-1:0] w_req_data = '0;
  logic              sram_ceb;
  logic              sram_web;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_d;
  logic [DATA_W-1:0] sram_q;
  logic              init_done;

  always #5 clock = ~clock;

  sram_port_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_addr(r_req_addr),
    .r_resp_valid(r_resp_valid), .r_resp_ready(r_resp_ready), .r_resp_data(r_resp_data),
    .w_req_valid(w_req_valid), .w_req_ready(w_req_ready), .w_req_addr(w_req_addr),
    .w_req_data(w_req_data),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_d(sram_d),
    .sram_q(sram_q), .init_done(init_done)
  );

  // Behavioural macro: q is valid only the cycle after a read, garbage otherwise.
  bit [DATA_W-1:0] macro_mem [DEPTH];
  always @(posedge clock) begin
    if (!sram_ceb && !sram_web) macro_mem[sram_a] <= sram_d;
    if (!sram_ceb && sram_web) sram_q <= macro_mem[sram_a];
    else                       sram_q <= {$urandom, $urandom};
  end

  // Reference: memory contents as implied by accepted write requests.
  bit [DATA_W-1:0] ref_mem [DEPTH];

  typedef struct packed {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;
  exp_t exp_q[$];

  int total;
  int bad;
  int cyc;
  bit held;
  logic [DATA_W-1:0] held_data;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor / scoreboard
  exp_t e;
  always @(negedge clock) begin
    if (reset) begin
      chk("reset_ctl", 64'({r_req_ready, w_req_ready, r_resp_valid, sram_ceb, sram_web}), 64'b00011);
      chk("reset_addr_data", 64'({sram_a != '0, sram_d != '0}), 64'd0);
      exp_q.delete();
      held = 1'b0;
    end else begin
      chk("single_grant", 64'(r_req_ready && w_req_ready), 64'd0);
      if (r_resp_valid) begin
        if (!held) begin
          chk("unexpected_resp", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("resp_data", r_resp_data, e.data);
            chk("resp_latency", 64'(cyc), 64'(e.cyc + 2));
            held      = 1'b1;
            held_data = e.data;
          end
        end else begin
          chk("resp_stable", r_resp_data, held_data);
        end
        if (r_resp_ready) held = 1'b0;
      end else begin
        chk("resp_dropped", 64'(held), 64'd0);
      end
      if (r_req_valid && r_req_ready) begin
        chk("read_while_busy", 64'({exp_q.size() != 0, held}), 64'd0);
        exp_q.push_back('{data: ref_mem[r_req_addr], cyc: cyc});
      end
      if (w_req_valid && w_req_ready) ref_mem[w_req_addr] = w_req_data;
    end
  end

  task automatic drive(input bit rv, input int ra, input bit wv, input int wa,
                       input logic [DATA_W-1:0] wd, input bit rr);
    r_req_valid  = rv;
    r_req_addr   = ADDR_W'(ra);
    w_req_valid  = wv;
    w_req_addr   = ADDR_W'(wa);
    w_req_data   = wd;
    r_resp_ready = rr;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Requests are held valid through reset and INIT to prove readies stay low.
  task automatic apply_reset(input int n);
    next_cycle();
    reset = 1'b1;
    drive(1, 1, 1, 2, 64'h1, 1);
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
`ifdef SRAM_ARB_INIT_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 0) next_cycle();
      @(negedge clock);
      chk("init_write", 64'({sram_ceb, sram_web, sram_a == ADDR_W'(i), sram_d == '0,
                            init_done, r_req_ready, w_req_ready}), 64'b0011000);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
    @(negedge clock);
    chk("init_cycle", 64'({init_done, sram_ceb, r_req_ready, w_req_ready}), 64'b0100);
`endif
    next_cycle();
    drive(0, 0, 0, 0, '0, 1);
    @(negedge clock);
    chk("init_done", 64'(init_done), 64'd1);
  endtask

  bit exp_rd;

  initial begin
    apply_reset(3);

    // Write then read the same address on back-to-back cycles.
    next_cycle(); drive(0, 0, 1, 5, 64'hA5, 1);
    @(negedge clock);
    chk("wr_grant", 64'(w_req_ready), 64'd1);
    chk("wr_pins", 64'({sram_ceb, sram_web, sram_a, sram_d[7:0]}), 64'({1'b0, 1'b0, 7'd5, 8'hA5}));
    next_cycle(); drive(1, 5, 0, 0, '0, 1);
    @(negedge clock);
    chk("rd_grant", 64'(r_req_ready), 64'd1);
    chk("rd_pins", 64'({sram_ceb, sram_web, sram_a}), 64'({1'b0, 1'b1, 7'd5}));
    next_cycle(); drive(0, 0, 0, 0, '0, 1);
    @(negedge clock);
    chk("idle_ceb", 64'(sram_ceb), 64'd1);
    next_cycle();
    @(negedge clock);
    chk("raw_resp", 64'({r_resp_valid, r_resp_data[7:0]}), 64'({1'b1, 8'hA5}));
    repeat (2) next_cycle();

    // Contention: last grant was a read, so the first contested grant is a write.
    exp_rd = 1'b0;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      drive(1, $urandom_range(0, 15), 1, $urandom_range(0, 15), {$urandom, $urandom}, 1);
      @(negedge clock);
      chk("alternate", 64'({r_req_ready, w_req_ready}), 64'({exp_rd, !exp_rd}));
      exp_rd = !exp_rd;
    end
    next_cycle(); drive(0, 0, 0, 0, '0, 1);
    repeat (3) next_cycle();

    // Back-pressured response: writes keep flowing, reads wait.
    next_cycle(); drive(0, 0, 1, 9, 64'h3C, 0);
    @(negedge clock);
    chk("bp_wr_grant", 64'(w_req_ready), 64'd1);
    next_cycle(); drive(1, 9, 0, 0, '0, 0);
    @(negedge clock);
    chk("bp_rd_grant", 64'(r_req_ready), 64'd1);
    next_cycle(); drive(1, 9, 1, 20, {$urandom, $urandom}, 0);
    @(negedge clock);
    chk("bp_inflight", 64'({r_req_ready, w_req_ready}), 64'b01);
    for (int i = 0; i < 5; i++) begin
      next_cycle(); drive(1, 9, 1, 20, {$urandom, $urandom}, 0);
      @(negedge clock);
      chk("bp_hold", 64'({r_resp_valid, r_resp_data[7:0], r_req_ready, w_req_ready}),
          64'({1'b1, 8'h3C, 1'b0, 1'b1}));
    end
    next_cycle(); drive(1, 9, 1, 20, {$urandom, $urandom}, 1);
    @(negedge clock);
    chk("bp_release", 64'({r_resp_valid, r_req_ready, w_req_ready}), 64'b110);
    next_cycle(); drive(0, 0, 0, 0, '0, 1);
    repeat (3) next_cycle();

    // Reset one cycle after a read grant discards that read.
    next_cycle(); drive(1, 3, 0, 0, '0, 1);
    @(negedge clock);
    chk("pre_reset_rd", 64'(r_req_ready), 64'd1);
    apply_reset(2);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); drive(0, 0, 0, 0, '0, 1);
      @(negedge clock);
      chk("no_resp_after_reset", 64'(r_resp_valid), 64'd0);
    end

    // Randomized traffic over a small address window to force RAW hazards.
    for (int i = 0; i < 600; i++) begin
      next_cycle();
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 15),
            $urandom_range(0, 1) != 0, $urandom_range(0, 15),
            {$urandom, $urandom}, $urandom_range(0, 3) != 0);
    end
    next_cycle(); drive(0, 0, 0, 0, '0, 1);
    repeat (6) next_cycle();
    @(negedge clock);
    chk("drain", 64'({exp_q.size() != 0, held}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 64, word width.
- DEPTH, 128, macro word count.
- ADDR_W, 7, address width (= log2 DEPTH).
REQ-002 Ports SHALL be, one per line:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- r_req_valid  in  1  read request valid.
- r_req_ready  out  1  read request accepted.
- r_req_addr  in  ADDR_W  read address.
- r_resp_valid  out  1  read data valid.
- r_resp_ready  in  1  read data consumed.
- r_resp_data  out  DATA_W  read data.
- w_req_valid  in  1  write request valid.
- w_req_ready  out  1  write request accepted.
- w_req_addr  in  ADDR_W  write address.
- w_req_data  in  DATA_W  write data.
- sram_ceb  out  1  macro chip enable, active low.
- sram_web  out  1  macro write enable, active low (high = read).
- sram_a  out  ADDR_W  macro address.
- sram_d  out  DATA_W  macro write data.
- sram_q  in  DATA_W  macro read data; valid only in the cycle after a read access.
- init_done  out  1  controller accepting requests.

Function
REQ-003 The block SHALL issue at most one macro access per cycle; sram_ceb/web/a/d are combinational from the cycle's grant, and sram_ceb=1 in idle cycles.
REQ-004 A read SHALL be eligible only when the block is in RUN, no read is in flight, and (resp buffer empty or r_resp_valid&&r_resp_ready this cycle).
REQ-005 A write SHALL be eligible whenever the block is in RUN.
REQ-006 If only one requester is valid and eligible, that requester SHALL be granted.
REQ-007 If both are valid and eligible, the grant SHALL go to the side opposite last_grant; last_grant updates on every grant.
REQ-008 r_req_ready/w_req_ready SHALL be high exactly in the cycle the respective request is granted; handshake = valid&&ready.
REQ-009 Read granted in cycle N: sram_ceb=0, sram_web=1, sram_a=r_req_addr; at end of N+1 sram_q SHALL be captured into the resp buffer; r_resp_valid high from N+2 until r_resp_valid&&r_resp_ready.
REQ-010 Write granted in cycle N: sram_ceb=0, sram_web=0, sram_a=w_req_addr, sram_d=w_req_data; no response.
REQ-011 r_resp_data SHALL hold stable while r_resp_valid is high and unconsumed.
REQ-012 Read granted the cycle after a write to the same address SHALL return the new data (macro ordering, no bypass needed).
REQ-013 Sustained read throughput SHALL be one read per 2 cycles with r_resp_ready held high.
REQ-014 State machine SHALL be INIT -> RUN; RUN is terminal until reset; init_done=1 exactly in RUN.

Reset
REQ-015 With reset high, the block SHALL drive: r_req_ready=0, w_req_ready=0, r_resp_valid=0, sram_ceb=1, sram_web=1, sram_a=0, sram_d=0.
REQ-016 Reset SHALL set last_grant=write (first contested grant goes to read), clear the in-flight flag and resp buffer, set the init address to 0, and select INIT.
REQ-017 Reset mid-operation SHALL discard any in-flight read; no response for it is produced.

Configuration
REQ-018 Macro SRAM_ARB_INIT_CLEAR_EN defined:
- INIT writes 0 to addresses 0..DEPTH-1, one per cycle (sram_ceb=0, sram_web=0, sram_d=0).
- Both readies stay low during INIT.
- The block enters RUN in the cycle after the DEPTH-1 write.
- Reset during INIT restarts at address 0.
REQ-019 Macro undefined: INIT SHALL last exactly one cycle after reset deasserts, with no macro access.

Verification
REQ-020 Macro defined, DEPTH=128: release reset -> 128 zero-writes to addresses 0..127 on consecutive cycles, then init_done=1 one cycle later.
REQ-021 Write addr 5 data 0xA5 in cycle N, read addr 5 in N+1 -> r_resp_valid in N+3 with r_resp_data=0xA5.
REQ-022 Both valid every cycle, r_resp_ready=1 -> grants alternate read, write, read...; no read is granted while one is in flight.
REQ-023 Read returns 0x3C, r_resp_ready=0 for 5 cycles -> r_resp_valid and data stay stable, r_req_ready=0 and writes are still granted; then 1 cycle of ready -> consumed, next read granted in that same cycle.
REQ-024 Assert reset one cycle after a read grant -> no r_resp_valid after reset; outputs at reset values (REQ-015).
